vga_csr_arbiter: RTL

Two-port arbiter and protocol converter directly upstream of the CSR video SRAM slave. It merges a 16-bit Wishbone slave port (CPU access to video memory) and a read-only video fetch port into the single CSR master bus that drives the SRAM slave. It tracks the slave's fixed two-cycle read latency with a tag pipeline, so each read is acknowledged to the port that issued it. The video port has priority; at most one access per port is outstanding.

---
 rtl/vga_csr_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vga_csr_arbiter.sv
// vga_csr_arbiter
//
// Merges a 16-bit Wishbone slave port (CPU access to video memory) and a
// read-only video fetch port onto the single CSR master bus of the video SRAM.
// The SRAM answers reads a fixed RD_LAT cycles after the issue cycle; a small
// tag pipeline remembers which port issued each read so the returned word is
// acknowledged to that port only.
//
// Handshake: a port raises its strobe (Wishbone: stb & cyc) and holds it until
// it sees a one-cycle ack. Each port has at most one access outstanding; its
// pend flag is set on issue and cleared on the cycle its ack is driven. A new
// request is accepted at the earliest in the cycle after the ack.
//
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   wb_adr_i .. wb_cyc_i    Wishbone request (word address, lanes, we, data)
//   wb_dat_o, wb_ack_o      Wishbone read data / one-cycle ack
//   vid_adr_i, vid_stb_i    video fetch request
//   vid_dat_o, vid_ack_o    fetched word / one-cycle ack
//   csr_adr_o .. csr_dat_o  CSR master bus towards the SRAM (all registered)
//   csr_dat_i               SRAM read data, valid RD_LAT cycles after issue
`timescale 1ns/1ps
module vga_csr_arbiter #(
  parameter int RD_LAT = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [16:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic [16:0] vid_adr_i,
  input  logic        vid_stb_i,
  output logic [15:0] vid_dat_o,
  output logic        vid_ack_o,
  output logic [16:0] csr_adr_o,
  output logic [1:0]  csr_sel_o,
  output logic        csr_we_o,
  output logic [15:0] csr_dat_o,
  input  logic [15:0] csr_dat_i
);

  // One extra stage beyond the slave latency: the tag sits in the last stage
  // during the cycle csr_dat_i is valid and retires at the end of it.
  localparam int   STAGES  = RD_LAT + 1;
  localparam logic OWN_VID = 1'b0;
  localparam logic OWN_WB  = 1'b1;

  logic              vid_pend;
  logic              wb_pend;
  logic [STAGES-1:0] tag_vld;
  logic [STAGES-1:0] tag_own;

  logic vid_elig;
  logic wb_elig;
  logic grant_vid;
  logic grant_wb;
  logic push_rd;
  logic ret_vid;
  logic ret_wb;
  logic vid_ack_next;
  logic wb_ack_next;

  always_comb begin
    vid_elig  = vid_stb_i & ~vid_pend & ~vid_ack_o;
    wb_elig   = wb_stb_i & wb_cyc_i & ~wb_pend & ~wb_ack_o;
    // Video has priority; since video is blocked for several cycles after
    // each grant, Wishbone always finds a free slot between video reads.
    grant_vid = vid_elig;
    grant_wb  = wb_elig & ~vid_elig;
    push_rd   = grant_vid | (grant_wb & ~wb_we_i);
    ret_vid   = tag_vld[STAGES-1] & (tag_own[STAGES-1] == OWN_VID);
    ret_wb    = tag_vld[STAGES-1] & (tag_own[STAGES-1] == OWN_WB);
    vid_ack_next = ret_vid;
    // Only Wishbone issues writes, so a write on the bus now means the
    // Wishbone write ack goes out next cycle. A read retiring after the
    // master dropped cyc is swallowed.
    wb_ack_next  = csr_we_o | (ret_wb & wb_cyc_i);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      csr_adr_o <= '0;
      csr_sel_o <= '0;
      csr_we_o  <= 1'b0;
      csr_dat_o <= '0;
      wb_dat_o  <= '0;
      wb_ack_o  <= 1'b0;
      vid_dat_o <= '0;
      vid_ack_o <= 1'b0;
      vid_pend  <= 1'b0;
      wb_pend   <= 1'b0;
      tag_vld   <= '0;
      tag_own   <= '0;
    end else begin
      // CSR bus: idle cycles keep address/data but never assert we.
      if (grant_vid) begin
        csr_adr_o <= vid_adr_i;
        csr_sel_o <= 2'b11;
        csr_we_o  <= 1'b0;
      end else if (grant_wb) begin
        csr_adr_o <= wb_adr_i;
        csr_sel_o <= wb_sel_i;
        csr_we_o  <= wb_we_i;
        csr_dat_o <= wb_dat_i;
      end else begin
        csr_sel_o <= 2'b00;
        csr_we_o  <= 1'b0;
      end

      // Tag pipeline: reads only.
      tag_vld[0] <= push_rd;
      tag_own[0] <= grant_wb ? OWN_WB : OWN_VID;
      for (int i = 1; i < STAGES; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end

      vid_ack_o <= vid_ack_next;
      if (ret_vid) begin
        vid_dat_o <= csr_dat_i;
      end
      wb_ack_o <= wb_ack_next;
      if (ret_wb & wb_cyc_i) begin
        wb_dat_o <= csr_dat_i;
      end

      if (grant_vid) begin
        vid_pend <= 1'b1;
      end else if (vid_ack_next) begin
        vid_pend <= 1'b0;
      end

      // An aborted read still frees the port when its tag retires.
      if (grant_wb) begin
        wb_pend <= 1'b1;
      end else if (wb_ack_next | ret_wb) begin
        wb_pend <= 1'b0;
      end
    end
  end

endmodule
